// File: rtl/pwm_fade_ctrl_pkg.sv
// Shared types and defaults for the breathing-LED duty sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pwm_fade_ctrl_pkg;

  // Default duty word width, matching the PWM generator's duty input
  localparam int DUTY_W_DEF = 4;

  // Sequencer states; encoding is fixed so state values stay stable across revisions
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_UP      = 3'd1,
    ST_HOLD_HI = 3'd2,
    ST_DOWN    = 3'd3,
    ST_HOLD_LO = 3'd4
  } fade_state_e;

endpackage

// File: rtl/pwm_fade_ctrl_if.sv
// Control/status bundle between top-level control and the fade sequencer.
// Latency: n/a (wires only).
// Backpressure: none; start/stop/mode are levels sampled every cycle.
interface pwm_fade_ctrl_if
  import pwm_fade_ctrl_pkg::*;
#(
  parameter int DUTY_W = DUTY_W_DEF
);
  logic              start;
  logic              stop;
  logic              mode;
  logic [DUTY_W-1:0] max_duty;
  logic [DUTY_W-1:0] duty;
  logic              busy;
  logic              done;

  // Control side: issues commands, observes duty and status
  modport master (
    output start, stop, mode, max_duty,
    input  duty, busy, done
  );

  // Sequencer side
  modport slave (
    input  start, stop, mode, max_duty,
    output duty, busy, done
  );
endinterface

// File: rtl/pwm_fade_ctrl_step_prescaler.sv
// Step-rate prescaler: divides clk into one tick every STEP_DIV cycles while enabled.
// Latency: tick is combinational from the registered count; clr takes effect next edge.
// Backpressure: none; clr has priority over counting.
module step_prescaler #(
  parameter int STEP_DIV   = 50000,
  parameter int PRESCALE_W = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);
  localparam logic [PRESCALE_W-1:0] PCNT_LAST = PRESCALE_W'(STEP_DIV - 1);

  logic [PRESCALE_W-1:0] pcnt_q;
  logic [PRESCALE_W-1:0] pcnt_d;

  assign tick_o = en_i & (pcnt_q == PCNT_LAST);

  // Next count: clear wins, otherwise count 0..STEP_DIV-1 and wrap while enabled
  always_comb begin
    pcnt_d = pcnt_q;
    if (clr_i) begin
      pcnt_d = '0;
    end else if (en_i) begin
      pcnt_d = (pcnt_q == PCNT_LAST) ? '0 : pcnt_q + 1'b1;
    end
  end

  // Count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end
endmodule

// File: rtl/pwm_fade_ctrl.sv
// Breathing-LED sequencer: ramps duty 0->max, holds, ramps to 0, holds; single-shot or looping.
// Latency: start accepted at the next edge; each step lands STEP_DIV edges after the previous.
// Backpressure: none; start while busy is ignored, stop aborts at the next edge.
module pwm_fade_ctrl
  import pwm_fade_ctrl_pkg::*;
#(
  parameter int DUTY_W     = DUTY_W_DEF,
  parameter int STEP_DIV   = 50000,
  parameter int PRESCALE_W = 16,
  parameter int HOLD_STEPS = 8
) (
  input  logic            clk,
  input  logic            rst,
  pwm_fade_ctrl_if.slave  ctrl_if
);
  localparam int                HOLD_W    = $clog2(HOLD_STEPS + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_STEPS - 1);

  fade_state_e       state_q;
  logic [DUTY_W-1:0] duty_q;
  logic [DUTY_W-1:0] max_q;
  logic [HOLD_W-1:0] hold_q;
  logic              busy_q;
  logic              done_q;
  logic              tick;
  logic              start_acc;
  logic              pcnt_clr;

  // A start only counts from IDLE and never when stop is also present
  assign start_acc = (state_q == ST_IDLE) & ctrl_if.start & ~ctrl_if.stop;
  // Restart the step grid on every accepted start and every abort
  assign pcnt_clr  = ctrl_if.stop | start_acc;

  step_prescaler #(
    .STEP_DIV   (STEP_DIV),
    .PRESCALE_W (PRESCALE_W)
  ) u_step_prescaler (
    .clk    (clk),
    .rst    (rst),
    .en_i   (busy_q),
    .clr_i  (pcnt_clr),
    .tick_o (tick)
  );

  // Sequencer FSM with registered duty, busy and done outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      duty_q  <= '0;
      max_q   <= '0;
      hold_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (ctrl_if.stop) begin
        state_q <= ST_IDLE;
        duty_q  <= '0;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (ctrl_if.start) begin
              state_q <= ST_UP;
              duty_q  <= '0;
              max_q   <= ctrl_if.max_duty;
              hold_q  <= '0;
              busy_q  <= 1'b1;
            end
          end
          ST_UP: begin
            if (tick) begin
              // Compare before incrementing so duty saturates at the peak
              if (duty_q >= max_q) begin
                state_q <= ST_HOLD_HI;
                hold_q  <= '0;
              end else begin
                duty_q <= duty_q + 1'b1;
              end
            end
          end
          ST_HOLD_HI: begin
            if (tick) begin
              hold_q <= hold_q + 1'b1;
              if (hold_q == HOLD_LAST) begin
                state_q <= ST_DOWN;
              end
            end
          end
          ST_DOWN: begin
            if (tick) begin
              if (duty_q == '0) begin
                state_q <= ST_HOLD_LO;
                hold_q  <= '0;
              end else begin
                duty_q <= duty_q - 1'b1;
              end
            end
          end
          ST_HOLD_LO: begin
            if (tick) begin
              hold_q <= hold_q + 1'b1;
              if (hold_q == HOLD_LAST) begin
                if (ctrl_if.mode) begin
                  // Loop again with the same latched peak
                  state_q <= ST_UP;
                end else begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                end
              end
            end
          end
          default: begin
            state_q <= ST_IDLE;
            duty_q  <= '0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign ctrl_if.duty = duty_q;
  assign ctrl_if.busy = busy_q;
  assign ctrl_if.done = done_q;
endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Scoreboard bench for pwm_fade_ctrl: directed scenarios plus randomized control traffic.
// Latency: expected outputs are queued one edge ahead and popped after each edge.
// Backpressure: n/a.
module tb_pwm_fade_ctrl;
  localparam int S = 4;   // STEP_DIV
  localparam int H = 2;   // HOLD_STEPS

  typedef struct packed {
    logic [3:0] duty;
    logic       busy;
    logic       done;
  } exp_t;

  logic clk;
  logic rst;

  pwm_fade_ctrl_if #(.DUTY_W(4)) bus ();

  pwm_fade_ctrl #(
    .DUTY_W     (4),
    .STEP_DIV   (S),
    .PRESCALE_W (4),
    .HOLD_STEPS (H)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ctrl_if (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  exp_t sb[$];
  int   checks     = 0;
  int   failures   = 0;
  int   cyc        = 0;
  bit   mon_en     = 0;
  int   start_edge = 0;
  int   done_edge  = -1;
  int   done_peak  = -1;
  int   peak       = 0;

  // Reference model state: a sequence is "ticks since start" on a STEP_DIV grid
  bit   m_busy = 0;
  int   m_max  = 0;
  int   m_cyc  = 0;
  int   m_tick = 0;
  int   m_duty = 0;

  // Duty after t ticks of one pass with peak m: ramp up, hold, ramp down, hold low
  function automatic int duty_after(input int t, input int m);
    if (t <= m) return t;
    if (t <= m + 1 + H) return m;
    if (t <= 2 * m + 1 + H) return m - (t - (m + 1 + H));
    return 0;
  endfunction

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp_v);
    end
  endtask

  // Drive one cycle of inputs and queue what the outputs must be after the next edge
  task automatic cyc_drive(input logic st, input logic sp, input logic md, input logic [3:0] mx);
    exp_t e;
    int   len;
    @(negedge clk);
    mon_en       = 1;
    rst          = 1'b0;
    bus.start    = st;
    bus.stop     = sp;
    bus.mode     = md;
    bus.max_duty = mx;
    e.done = 1'b0;
    if (sp) begin
      m_busy = 0;
      m_duty = 0;
    end else if (!m_busy) begin
      if (st) begin
        m_busy     = 1;
        m_max      = int'(mx);
        m_cyc      = 0;
        m_tick     = 0;
        m_duty     = 0;
        start_edge = cyc + 1;
      end
    end else begin
      m_cyc++;
      if (m_cyc % S == 0) begin
        m_tick++;
        len    = 2 * (m_max + 1) + 2 * H;
        m_duty = duty_after(m_tick, m_max);
        if (m_tick == len) begin
          m_duty = 0;
          if (md) begin
            m_tick = 0;
          end else begin
            m_busy = 0;
            e.done = 1'b1;
          end
        end
      end
    end
    e.duty = 4'(m_duty);
    e.busy = m_busy;
    sb.push_back(e);
  endtask

  // Assert reset between edges and confirm outputs clear without any clock edge
  task automatic async_reset();
    exp_t e;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_duty", int'(bus.duty), 0);
    chk("arst_busy", int'(bus.busy), 0);
    chk("arst_done", int'(bus.done), 0);
    m_busy = 0;
    m_duty = 0;
    m_max  = 0;
    e = '0;
    sb.push_back(e);
  endtask

  task automatic idle(input int n, input logic md, input logic [3:0] mx);
    for (int i = 0; i < n; i++) cyc_drive(1'b0, 1'b0, md, mx);
  endtask

  // Monitor: after each edge pop the expected outputs and compare
  initial begin
    exp_t e;
    wait (mon_en);
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_underflow cyc=%0d actual=empty required=entry", cyc);
      end else begin
        e = sb.pop_front();
        if ({bus.duty, bus.busy, bus.done} !== e) begin
          failures++;
          $display("FAIL cycle_out cyc=%0d actual duty=%0d busy=%0b done=%0b required duty=%0d busy=%0b done=%0b",
                   cyc, bus.duty, bus.busy, bus.done, e.duty, e.busy, e.done);
        end
      end
      if (bus.done) begin
        done_edge = cyc;
        done_peak = peak;
      end
      if (bus.busy) begin
        if (int'(bus.duty) > peak) peak = int'(bus.duty);
      end else begin
        peak = 0;
      end
    end
  end

  initial begin
    logic       st;
    logic       sp;
    logic       md;
    logic [3:0] mx;
    int         s0;

    rst          = 1'b0;
    bus.start    = 1'b0;
    bus.stop     = 1'b0;
    bus.mode     = 1'b0;
    bus.max_duty = '0;
    #1 rst = 1'b1;
    #2;
    chk("reset_duty", int'(bus.duty), 0);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_done", int'(bus.done), 0);

    idle(2, 1'b0, 4'd3);

    // Single-shot peak 3; restart attempt while busy and max_duty change must be ignored
    cyc_drive(1'b1, 1'b0, 1'b0, 4'd3);
    s0 = start_edge;
    for (int i = 1; i < 60; i++) cyc_drive(i == 20, 1'b0, 1'b0, (i >= 2) ? 4'd7 : 4'd3);
    chk("ss_done_edge", done_edge - s0, 48);
    chk("ss_peak", done_peak, 3);

    // Zero peak: duty never leaves 0, done after 6 ticks
    cyc_drive(1'b1, 1'b0, 1'b0, 4'd0);
    s0 = start_edge;
    idle(30, 1'b0, 4'd0);
    chk("zero_done_edge", done_edge - s0, 24);
    chk("zero_peak", done_peak, 0);

    // Full-scale peak: reaches 15 with no wrap
    cyc_drive(1'b1, 1'b0, 1'b0, 4'd15);
    s0 = start_edge;
    idle(150, 1'b0, 4'd15);
    chk("max_done_edge", done_edge - s0, 144);
    chk("max_peak", done_peak, 15);

    // Continuous loop, then drop to single-shot to let it finish
    cyc_drive(1'b1, 1'b0, 1'b1, 4'd3);
    idle(70, 1'b1, 4'd3);
    idle(60, 1'b0, 4'd3);

    // Stop mid-ramp
    cyc_drive(1'b1, 1'b0, 1'b0, 4'd3);
    idle(9, 1'b0, 4'd3);
    cyc_drive(1'b0, 1'b1, 1'b0, 4'd3);
    idle(5, 1'b0, 4'd3);

    // Start and stop together while idle
    cyc_drive(1'b1, 1'b1, 1'b0, 4'd3);
    idle(3, 1'b0, 4'd3);

    // Start held high: restart is accepted in the done cycle
    for (int i = 0; i < 60; i++) cyc_drive(1'b1, 1'b0, 1'b0, 4'd2);
    cyc_drive(1'b0, 1'b1, 1'b0, 4'd2);

    // Reset during the up ramp
    cyc_drive(1'b1, 1'b0, 1'b0, 4'd5);
    idle(6, 1'b0, 4'd5);
    async_reset();
    idle(3, 1'b0, 4'd5);

    // Randomized control traffic
    md = 1'b0;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 1499) == 0) begin
        async_reset();
      end else begin
        st = ($urandom_range(0, 39) == 0);
        sp = ($urandom_range(0, 399) == 0);
        if ($urandom_range(0, 199) == 0) md = ~md;
        mx = 4'($urandom_range(0, 15));
        cyc_drive(st, sp, md, mx);
      end
    end

    idle(1, 1'b0, 4'd0);
    @(posedge clk);
    #2;
    chk("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pwm_fade_ctrl.md
Name: pwm_fade_ctrl

Overview:
- Sequencer for the 4-bit PWM duty input: ramps duty 0 -> max, holds, ramps back to 0, holds ("breathing" LED).
- Runs single-shot or continuously.
- Sits between top-level control (buttons/registers) and the PWM generator. The PWM generator free-runs; this block only drives its duty word.

Parameters:
- DUTY_W, 4, duty word width; must match PWM duty input.
- STEP_DIV, 50000, clock cycles per step tick (>= 2).
- PRESCALE_W, 16, prescaler counter width; must satisfy 2^PRESCALE_W >= STEP_DIV.
- HOLD_STEPS, 8, ticks spent in each hold state (>= 1).

Ports:
- clk, input, 1: system clock.
- rst, input, 1: asynchronous, active-high reset.
- start, input, 1: level; sampled each cycle; starts a sequence when idle.
- stop, input, 1: level; aborts any sequence.
- mode, input, 1: 0 = single-shot, 1 = continuous; sampled continuously.
- max_duty, input, DUTY_W: ramp peak; latched when start is accepted.
- duty, output, DUTY_W: registered duty word to the PWM generator.
- busy, output, 1: high whenever state != IDLE.
- done, output, 1: one-cycle pulse when a single-shot sequence completes.

Behaviour:
- Reset (async): state = IDLE, duty = 0, busy = 0, done = 0, prescaler = 0, hold counter = 0, latched max = 0.
- Prescaler: counts 0..STEP_DIV-1 only while busy, then wraps. tick = busy & (pcnt == STEP_DIV-1). Prescaler is cleared on the start-accept edge. FSM actions on a tick take effect at edges k*STEP_DIV after start.
- States: IDLE, UP, HOLD_HI, DOWN, HOLD_LO.
- IDLE: if start & !stop, then at the next edge: state = UP, duty = 0, latch max_duty, pcnt = 0, hold counter = 0.
- UP, on tick: if duty >= latched max, go to HOLD_HI and clear the hold counter; else duty += 1.
- HOLD_HI, on tick: hold counter += 1; when it reaches HOLD_STEPS, go to DOWN.
- DOWN, on tick: if duty == 0, go to HOLD_LO and clear the hold counter; else duty -= 1.
- HOLD_LO, on tick: hold counter += 1; at HOLD_STEPS:
  - mode = 1: go to UP (duty stays 0; latched max is retained).
  - mode = 0: go to IDLE and pulse done for exactly one cycle.
- Tick count per single-shot sequence: 2*(M+1) + 2*HOLD_STEPS, where M = latched max.
- max_duty = 0: UP moves to HOLD_HI on its first tick; duty never leaves 0.
- Duty arithmetic: never wraps. Increment stops at the latched max; decrement stops at 0.
- stop has priority over everything. When asserted in any state, at the next edge: state = IDLE, duty = 0, pcnt = 0, no done pulse. stop and start in the same cycle resolves to IDLE.
- start while busy is ignored (no restart, no re-latch).
- max_duty changes mid-sequence have no effect until the next accepted start.
- done and start coincide: done pulses in the IDLE cycle; a start sampled in that cycle is accepted normally.
- rst mid-sequence: immediate return to reset values, regardless of clk.
- Outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package:
  - state encoding constants (IDLE = 0, UP = 1, HOLD_HI = 2, DOWN = 3, HOLD_LO = 4; 3 bits)
  - DUTY_W default
- One sub-module, step_prescaler (clk, rst, en, clr -> tick), holds the STEP_DIV counter. The FSM, duty register and hold counter stay in pwm_fade_ctrl.

Test Plan:
- Reset mid-run: assert rst at an arbitrary point during UP -> duty = 0, busy = 0, done = 0 immediately, with no clk edge required.
- Single-shot, STEP_DIV = 4, HOLD_STEPS = 2, max_duty = 3, mode = 0, start pulsed at edge 0:
  - duty steps 1, 2, 3 at edges 4, 8, 12.
  - HOLD_HI at 16; DOWN at 24; duty 2, 1, 0 at 28, 32, 36.
  - HOLD_LO at 40; IDLE with done = 1 in the cycle after edge 48 only; busy falls at the same edge.
- Continuous, same parameters, mode = 1 -> after edge 48, state = UP with duty = 0; duty = 1 at edge 52; done never asserts.
- Edge cases:
  - max_duty = 0, single-shot -> duty stays 0 throughout; done after 2 + 2*2 = 6 ticks (edge 24).
  - max_duty = 15 -> duty peaks at 15 with no wrap to 0.
- Priority and latching:
  - stop at edge 10 mid-UP -> duty = 0, IDLE at edge 11, no done.
  - start and stop together in IDLE -> stays IDLE.
  - start re-pulsed while busy -> timeline unchanged.
  - max_duty changed to 7 after start -> peak remains 3.
